// File: rtl/fb_wb_arbiter.sv
//==========================================================================
// Module      : fb_wb_arbiter
// Description : Two-master round-robin arbiter for a pipelined Wishbone
//               framebuffer/DDR3 port. Holds a tenure per master, limits
//               outstanding strobes, and aborts a tenure whose slave stops
//               responding.
// Revision    : 1.0 - initial release
//==========================================================================
`timescale 1ns/1ps
`default_nettype none

module fb_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 15,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    // master 0 request / response
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [DW-1:0]   m0_wdata_i,
    output logic [DW-1:0]   m0_rdata_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    output logic            m0_stall_o,
    // master 1 request / response
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [DW-1:0]   m1_wdata_i,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic            m1_stall_o,
    // shared slave port
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [DW-1:0]   s_wdata_o,
    input  logic [DW-1:0]   s_rdata_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    input  logic            s_stall_i
);

    localparam int c_out_w = $clog2(MAX_OUT + 1);
    localparam int c_to_w  = $clog2(TIMEOUT + 1);
    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUT);
    localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_own0  = 2'd1;
    localparam logic [1:0] c_st_own1  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    logic [1:0]         r_state;
    logic               r_owner;
    logic               r_last_owner;
    logic [c_out_w-1:0] r_outstanding;
    logic [c_to_w-1:0]  r_timeout;

    // Current owner's request, and the other master's cyc
    logic               w_own;
    logic               w_own_cyc;
    logic               w_own_stb;
    logic               w_own_we;
    logic [AW-1:0]      w_own_addr;
    logic [DW/8-1:0]    w_own_sel;
    logic [DW-1:0]      w_own_wdata;
    logic               w_oth_cyc;

    assign w_own       = (r_state == c_st_own0) || (r_state == c_st_own1);
    assign w_own_cyc   = r_owner ? m1_cyc_i   : m0_cyc_i;
    assign w_own_stb   = r_owner ? m1_stb_i   : m0_stb_i;
    assign w_own_we    = r_owner ? m1_we_i    : m0_we_i;
    assign w_own_addr  = r_owner ? m1_addr_i  : m0_addr_i;
    assign w_own_sel   = r_owner ? m1_sel_i   : m0_sel_i;
    assign w_own_wdata = r_owner ? m1_wdata_i : m0_wdata_i;
    assign w_oth_cyc   = r_owner ? m0_cyc_i   : m1_cyc_i;

    logic w_resp;
    logic w_full;
    logic w_busy;
    logic w_to_hit;
    logic w_s_stb;
    logic w_accept;

    assign w_resp   = s_ack_i | s_err_i | s_rty_i;
    assign w_full   = (r_outstanding == c_max_out);
    assign w_busy   = (r_outstanding != '0);
    // Abort fires only while the owner still holds cyc; a dropped cyc is a normal release
    assign w_to_hit = w_own & w_own_cyc & w_busy & ~w_resp & (r_timeout == c_to_last);
    // Strobes are withheld when the window is full or in the abort cycle
    assign w_s_stb  = w_own & w_own_cyc & w_own_stb & ~w_full & ~w_to_hit;
    assign w_accept = w_s_stb & ~s_stall_i;

    // Slave request path: only the owner's request, and only while owning
    assign s_cyc_o   = w_own & w_own_cyc;
    assign s_stb_o   = w_s_stb;
    assign s_we_o    = w_own & w_own_we;
    assign s_addr_o  = w_own ? w_own_addr  : '0;
    assign s_sel_o   = w_own ? w_own_sel   : '0;
    assign s_wdata_o = w_own ? w_own_wdata : '0;

    // Response to the owner; the non-owner always sees stall with no responses
    logic          w_o_ack;
    logic          w_o_err;
    logic          w_o_rty;
    logic          w_o_stall;
    logic [DW-1:0] w_o_rdata;

    assign w_o_ack   = w_own & s_ack_i;
    assign w_o_err   = w_own & (s_err_i | w_to_hit);
    assign w_o_rty   = w_own & s_rty_i;
    assign w_o_stall = ~w_own | s_stall_i | w_full | w_to_hit;
    assign w_o_rdata = w_own ? s_rdata_i : '0;

    assign m0_ack_o   = ~r_owner & w_o_ack;
    assign m0_err_o   = ~r_owner & w_o_err;
    assign m0_rty_o   = ~r_owner & w_o_rty;
    assign m0_stall_o =  r_owner | w_o_stall;
    assign m0_rdata_o =  r_owner ? '0 : w_o_rdata;

    assign m1_ack_o   =  r_owner & w_o_ack;
    assign m1_err_o   =  r_owner & w_o_err;
    assign m1_rty_o   =  r_owner & w_o_rty;
    assign m1_stall_o = ~r_owner | w_o_stall;
    assign m1_rdata_o =  r_owner ? w_o_rdata : '0;

    // Arbitration FSM with outstanding and timeout tracking; counters clear on every state change
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= c_st_idle;
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_outstanding <= '0;
            r_timeout     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_outstanding <= '0;
                    r_timeout     <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || r_last_owner)) begin
                        r_state <= c_st_own0;
                        r_owner <= 1'b0;
                    end else if (m1_cyc_i) begin
                        r_state <= c_st_own1;
                        r_owner <= 1'b1;
                    end
                end
                c_st_own0, c_st_own1: begin
                    if (!w_own_cyc) begin
                        r_last_owner  <= r_owner;
                        r_outstanding <= '0;
                        r_timeout     <= '0;
                        if (w_oth_cyc) begin
                            r_state <= r_owner ? c_st_own0 : c_st_own1;
                            r_owner <= ~r_owner;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else if (w_to_hit) begin
                        r_state       <= c_st_drain;
                        r_outstanding <= '0;
                        r_timeout     <= '0;
                    end else begin
                        if (w_accept && !w_resp) begin
                            r_outstanding <= r_outstanding + c_out_w'(1);
                        end else if (!w_accept && w_resp && w_busy) begin
                            r_outstanding <= r_outstanding - c_out_w'(1);
                        end
                        if (w_resp || !w_busy) begin
                            r_timeout <= '0;
                        end else begin
                            r_timeout <= r_timeout + c_to_w'(1);
                        end
                    end
                end
                c_st_drain: begin
                    r_outstanding <= '0;
                    r_timeout     <= '0;
                    if (!w_own_cyc) begin
                        r_state      <= c_st_idle;
                        r_last_owner <= r_owner;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
